// File: rtl/aww_types_pkg.sv
// aww_types_pkg: shared types for the pipeline hazard controller.
//   stall_t    - pipeline stall code driven to the datapath
//   hz_state_t - controller sequencing state
//   max_int    - elaboration-time helper for sizing the scoreboard counters
package aww_types_pkg;

    typedef enum logic [1:0] {
        NO_STALL   = 2'd0,
        IFID_STALL = 2'd1,
        IDEX_STALL = 2'd2,
        FULL_STALL = 2'd3
    } stall_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } hz_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: one down-counter per architectural register holding the
// number of advancing cycles before that register's value is usable by the
// instruction in ID.
// Optional feature macro: HAZARD_FWD_EN (forwarding present, only loads hazard).
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   issue                    instruction in ID issues this cycle
//   dec_en                   pipeline advances (counters decrement)
//   id_valid                 valid instruction in ID
//   id_rs/id_rt (+_used)     source registers and whether they are read
//   id_wsel, id_wen, id_load destination, write enable, load flag
//   hazard                   RAW hazard for the instruction in ID
//   all_zero                 no register has an outstanding write
module hazard_scoreboard
    import aww_types_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int LOAD_LAT = 1,
    parameter int WB_DIST  = 3,
    parameter int ZERO_REG = 1,
    localparam int RW      = $clog2(NREGS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          issue,
    input  logic          dec_en,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic [RW-1:0] id_wsel,
    input  logic          id_wen,
    input  logic          id_load,
    output logic          hazard,
    output logic          all_zero
);

`ifdef HAZARD_FWD_EN
    localparam int LOAD_VAL = LOAD_LAT;
    localparam int ALU_VAL  = 0;
`else
    localparam int LOAD_VAL = max_int(LOAD_LAT, WB_DIST);
    localparam int ALU_VAL  = WB_DIST;
`endif
    // At least one bit even when every latency is zero.
    localparam int CW = $clog2(max_int(max_int(LOAD_VAL, ALU_VAL), 1) + 1);

    logic [CW-1:0] cnt [NREGS];
    logic [CW-1:0] load_val;
    logic          track;
    logic          rs_busy;
    logic          rt_busy;

    assign load_val = id_load ? CW'(LOAD_VAL) : CW'(ALU_VAL);
    assign track    = issue && id_wen && !((ZERO_REG != 0) && (id_wsel == '0));

    // A new write to a register takes precedence over its decrement.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (track && (id_wsel == RW'(i)))
                    cnt[i] <= load_val;
                else if (dec_en && (cnt[i] != '0))
                    cnt[i] <= cnt[i] - CW'(1);
            end
        end
    end

    assign rs_busy = id_rs_used && (cnt[id_rs] != '0) && !((ZERO_REG != 0) && (id_rs == '0));
    assign rt_busy = id_rt_used && (cnt[id_rt] != '0) && !((ZERO_REG != 0) && (id_rt == '0));
    assign hazard  = id_valid && (rs_busy || rt_busy);

    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < NREGS; i++)
            if (cnt[i] != '0) all_zero = 1'b0;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage core. Drives
// pipeline-register stalls, flushes and the PC write enable from a registered
// register scoreboard, a data-memory wait FSM, a halt-drain sequence and a
// saturating stall counter.
// Optional feature macro: HAZARD_FWD_EN (see hazard_scoreboard).
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   id_*            instruction in ID (valid, sources, destination, load)
//   ihit            instruction fetch completed
//   dmem_req, dhit  data-memory request pending / completed
//   npc_change      taken branch/jump resolved in EX
//   halt            halt in ID/EX
//   stat_clr        clear stall counter
//   pipe_stall      stall code (stall_t), combinational
//   flush           [0] IF/ID, [1] ID/EX, [2] EX/MEM, [3] MEM/WB, combinational
//   pc_wen          PC write enable, combinational
//   halted          sticky halted flag, registered
//   stall_cnt       saturating count of stalled cycles, registered
//
// state  | meaning
// RUN    | normal operation
// DWAIT  | waiting on data memory, whole pipe frozen
// DRAIN  | halt seen, fetch squashed until scoreboard empties
// HALTED | stopped, only reset leaves
module hazard_ctrl
    import aww_types_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int LOAD_LAT = 1,
    parameter int WB_DIST  = 3,
    parameter int CNT_W    = 16,
    parameter int ZERO_REG = 1,
    localparam int RW      = $clog2(NREGS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             id_valid,
    input  logic [RW-1:0]    id_rs,
    input  logic [RW-1:0]    id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [RW-1:0]    id_wsel,
    input  logic             id_wen,
    input  logic             id_load,
    input  logic             ihit,
    input  logic             dmem_req,
    input  logic             dhit,
    input  logic             npc_change,
    input  logic             halt,
    input  logic             stat_clr,
    output stall_t           pipe_stall,
    output logic [3:0]       flush,
    output logic             pc_wen,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    hz_state_t state;
    logic      hazard;
    logic      all_zero;
    logic      issue;
    logic      dec_en;

    // A taken branch lets the instruction in ID go even while fetch is stalled.
    assign issue  = id_valid && ((pipe_stall == NO_STALL) ||
                                 ((pipe_stall == IFID_STALL) && npc_change));
    assign dec_en = (pipe_stall != FULL_STALL);

    hazard_scoreboard #(
        .NREGS    (NREGS),
        .LOAD_LAT (LOAD_LAT),
        .WB_DIST  (WB_DIST),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .CLK        (CLK),
        .RST        (RST),
        .issue      (issue),
        .dec_en     (dec_en),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .id_wsel    (id_wsel),
        .id_wen     (id_wen),
        .id_load    (id_load),
        .hazard     (hazard),
        .all_zero   (all_zero)
    );

    always_comb begin
        pipe_stall = NO_STALL;
        if (RST || (state == HALTED))
            pipe_stall = FULL_STALL;
        else if ((state == DWAIT) || ((state == RUN) && dmem_req && !dhit))
            pipe_stall = FULL_STALL;
        else if (hazard)
            pipe_stall = IDEX_STALL;
        else if (!ihit)
            pipe_stall = IFID_STALL;
    end

    always_comb begin
        flush  = 4'b0000;
        pc_wen = 1'b0;
        if (RST) begin
            flush = 4'b1111;
        end else begin
            if (pipe_stall == IDEX_STALL)
                flush[1] = 1'b1;
            if (npc_change && (pipe_stall != FULL_STALL))
                flush[1:0] = 2'b11;
            if (state == DRAIN)
                flush[0] = 1'b1;
            if ((state != DRAIN) && (state != HALTED))
                pc_wen = (npc_change && (pipe_stall != FULL_STALL)) ||
                         (pipe_stall == NO_STALL);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (dmem_req && !dhit) state <= DWAIT;
                    else if (halt)         state <= DRAIN;
                end
                DWAIT:   if (dhit) state <= RUN;
                DRAIN:   if (all_zero && !dmem_req) state <= HALTED;
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase
            halted <= halted || (state == HALTED);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || stat_clr)
            stall_cnt <= '0;
        else if ((pipe_stall != NO_STALL) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl in its default build (no forwarding).
// Parameters: LOAD_LAT=5, WB_DIST=3 so loads hold for 5 cycles and ALU
// writers for 3; CNT_W=4 so the stall counter saturates at 15.
module tb_hazard_ctrl;
    import aww_types_pkg::*;

    localparam logic [1:0] S_NO = 2'd0;
    localparam logic [1:0] S_IF = 2'd1;
    localparam logic [1:0] S_IX = 2'd2;
    localparam logic [1:0] S_FS = 2'd3;

    logic       CLK = 1'b0;
    logic       RST;
    logic       id_valid, id_rs_used, id_rt_used, id_wen, id_load;
    logic [4:0] id_rs, id_rt, id_wsel;
    logic       ihit, dmem_req, dhit, npc_change, halt, stat_clr;
    stall_t     pipe_stall;
    logic [3:0] flush;
    logic       pc_wen, halted;
    logic [3:0] stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    typedef struct {
        string      tag;
        logic [1:0] ps;
        logic [3:0] fl;
        logic       pw;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    hazard_ctrl #(
        .NREGS(32), .LOAD_LAT(5), .WB_DIST(3), .CNT_W(4), .ZERO_REG(1)
    ) dut (
        .CLK(CLK), .RST(RST),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wsel(id_wsel), .id_wen(id_wen), .id_load(id_load),
        .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .npc_change(npc_change), .halt(halt), .stat_clr(stat_clr),
        .pipe_stall(pipe_stall), .flush(flush), .pc_wen(pc_wen),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_wsel = 0; id_wen = 0; id_load = 0;
        ihit = 1; dmem_req = 0; dhit = 0; npc_change = 0; halt = 0; stat_clr = 0;
    endtask

    task automatic instr(input logic [4:0] rs, input logic rs_u, input logic [4:0] rt,
                         input logic rt_u, input logic [4:0] wsel, input logic wen,
                         input logic ld);
        id_valid = 1; id_rs = rs; id_rs_used = rs_u; id_rt = rt; id_rt_used = rt_u;
        id_wsel = wsel; id_wen = wen; id_load = ld;
    endtask

    // Called #1 after a rising edge with inputs already driven: queue the
    // expected combinational outputs, compare them mid-cycle, then cross the
    // edge and compare the stall counter.
    task automatic step(input string tag, input logic [1:0] ps, input logic [3:0] fl,
                        input logic pw);
        exp_t e;
        e.tag = tag; e.ps = ps; e.fl = fl; e.pw = pw;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        chk({e.tag, ".stall"}, 32'(pipe_stall), 32'(e.ps));
        chk({e.tag, ".flush"}, 32'(flush), 32'(e.fl));
        chk({e.tag, ".pc_wen"}, 32'(pc_wen), 32'(e.pw));
        if (RST || stat_clr)                    exp_cnt = 0;
        else if (e.ps != S_NO && exp_cnt != 15) exp_cnt++;
        @(posedge CLK);
        #1;
        chk({e.tag, ".cnt"}, 32'(stall_cnt), 32'(exp_cnt));
    endtask

    initial begin
        idle();
        RST = 1;
        step("rst0", S_FS, 4'hF, 0);
        step("rst1", S_FS, 4'hF, 0);
        chk("rst_halted", 32'(halted), 0);
        RST = 0;
        step("idle", S_NO, 4'h0, 1);

        // add r2 ; sub r3,r2,r2 -> WB_DIST stall cycles
        instr(1, 1, 1, 0, 2, 1, 0);  step("add_r2", S_NO, 4'h0, 1);
        instr(2, 1, 2, 1, 3, 1, 0);
        repeat (3) step("raw_stall", S_IX, 4'b0010, 0);
        step("raw_issue", S_NO, 4'h0, 1);
        chk("raw_cnt", 32'(stall_cnt), 3);
        idle();
        repeat (3) step("settle1", S_NO, 4'h0, 1);

        // register 0 is never tracked
        instr(1, 0, 1, 0, 0, 1, 0);  step("wr_r0", S_NO, 4'h0, 1);
        instr(0, 1, 0, 1, 4, 0, 0);  step("rd_r0", S_NO, 4'h0, 1);

        // load-use with a memory wait in the middle of the stall
        idle(); stat_clr = 1;        step("clr1", S_NO, 4'h0, 1);
        stat_clr = 0;
        instr(1, 1, 0, 0, 5, 1, 1);  step("lw_r5", S_NO, 4'h0, 1);
        instr(5, 1, 1, 1, 6, 1, 0);
        repeat (2) step("lu_stall", S_IX, 4'b0010, 0);
        dmem_req = 1; dhit = 0;
        repeat (4) step("dwait", S_FS, 4'h0, 0);
        dhit = 1;                    step("dwait_hit", S_FS, 4'h0, 0);
        dmem_req = 0; dhit = 0;
        repeat (3) step("lu_resume", S_IX, 4'b0010, 0);
        step("lu_issue", S_NO, 4'h0, 1);
        chk("lu_cnt", 32'(stall_cnt), 10);
        idle();
        repeat (3) step("settle2", S_NO, 4'h0, 1);
        dmem_req = 1; dhit = 1;      step("dmem_hit_run", S_NO, 4'h0, 1);
        idle(); stat_clr = 1;        step("clr2", S_NO, 4'h0, 1);
        stat_clr = 0;

        // branch coincident with a load-use hazard
        instr(1, 1, 0, 0, 7, 1, 1);  step("lw_r7", S_NO, 4'h0, 1);
        instr(7, 1, 0, 0, 8, 1, 0); npc_change = 1;
        step("br_hz", S_IX, 4'b0011, 1);
        idle();
        repeat (4) step("settle3", S_NO, 4'h0, 1);

        // fetch stall, and a branch issuing through a fetch stall
        ihit = 0;                    step("ifid", S_IF, 4'h0, 0);
        instr(1, 0, 1, 0, 9, 1, 0); npc_change = 1; ihit = 0;
        step("ifid_br", S_IF, 4'b0011, 1);
        npc_change = 0; ihit = 1;
        instr(9, 1, 0, 0, 10, 0, 0); step("ifid_br_dep", S_IX, 4'b0010, 0);
        idle();
        repeat (2) step("settle4", S_NO, 4'h0, 1);

        // stall counter saturation and clear
        stat_clr = 1;                step("clr3", S_NO, 4'h0, 1);
        stat_clr = 0; ihit = 0;
        repeat (20) step("sat", S_IF, 4'h0, 0);
        chk("sat_cnt", 32'(stall_cnt), 15);
        stat_clr = 1;                step("sat_clr", S_IF, 4'h0, 0);
        stat_clr = 0; ihit = 1;
        chk("sat_clr_cnt", 32'(stall_cnt), 0);

        // reset in DWAIT discards the pending load
        instr(1, 1, 0, 0, 11, 1, 1); step("lw_r11", S_NO, 4'h0, 1);
        idle(); dmem_req = 1;        step("dw_enter", S_FS, 4'h0, 0);
        RST = 1;                     step("rst_dwait", S_FS, 4'hF, 0);
        RST = 0; dmem_req = 0;
        instr(11, 1, 0, 0, 12, 0, 0); step("post_rst", S_NO, 4'h0, 1);

        // halt with a load pending: drain, then halted
        instr(1, 1, 0, 0, 5, 1, 1);  step("lw_h", S_NO, 4'h0, 1);
        idle(); halt = 1;            step("halt", S_NO, 4'h0, 1);
        halt = 0;
        repeat (5) begin
            step("drain", S_NO, 4'b0001, 0);
            chk("drain_halted", 32'(halted), 0);
        end
        step("halted0", S_FS, 4'h0, 0);
        chk("halted_rise", 32'(halted), 1);
        npc_change = 1;              step("halted_hold", S_FS, 4'h0, 0);
        npc_change = 0;
        chk("halted_sticky", 32'(halted), 1);
        RST = 1;                     step("rst_halt", S_FS, 4'hF, 0);
        RST = 0;
        chk("halted_clr", 32'(halted), 0);
        step("after_rst", S_NO, 4'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
